// File: rtl/mcp_pkg.sv
// Shared packet-decode definitions for the MCP configuration-read scoreboard.
// Field offsets describe the WIDTH-1 bit packet delivered by the UART RX path.
package mcp_pkg;

  typedef enum logic [1:0] {
    DATA      = 2'd0,
    TEST      = 2'd1,
    CFG_WRITE = 2'd2,
    CFG_READ  = 2'd3
  } packet_declare_t;

  localparam int DECL_LSB = 0;
  localparam int DECL_W   = 2;
  localparam int CHIP_LSB = 2;
  localparam int CHIP_W   = 8;
  localparam int ADDR_LSB = 10;
  localparam int ADDR_W   = 8;
  localparam int DATA_LSB = 18;
  localparam int DATA_W   = 8;

  localparam logic [7:0] GLOBAL_ID_DEFAULT = 8'd255;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mcp_prio_enc.sv
// Lowest-set-bit priority encoder with a found flag; purely combinational.
// No flow control: the index is meaningful only while found is high.
module mcp_prio_enc #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scanning downward lets the lowest set bit be the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcp_cfg_read_scoreboard.sv
// Tracks outstanding LArPix config reads and matches responses; stats enabled by MCP_SB_STATS_EN.
// Pulses registered one cycle after cause; req_ready drops while all DEPTH entries are in use.
module mcp_cfg_read_scoreboard
  import mcp_pkg::*;
#(
  parameter int         WIDTH     = 64,
  parameter int         DEPTH     = 8,
  parameter int         TIMEOUT_W = 16,
  parameter logic [7:0] GLOBAL_ID = GLOBAL_ID_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [7:0]                 req_chip_id,
  input  logic [7:0]                 req_addr,
  input  logic                       rx_valid,
  input  logic [WIDTH-2:0]           rx_data,
  input  logic                       rx_parity_error,
  input  logic [TIMEOUT_W-1:0]       timeout_cycles,
  output logic                       match_valid,
  output logic [7:0]                 match_chip_id,
  output logic [7:0]                 match_addr,
  output logic [7:0]                 match_data,
  output logic                       timeout_valid,
  output logic [7:0]                 timeout_chip_id,
  output logic [7:0]                 timeout_addr,
  output logic                       unexpected_valid,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic [15:0]                stat_match,
  output logic [15:0]                stat_timeout,
  output logic [15:0]                stat_unexpected,
  output logic [15:0]                stat_parity
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TIMEOUT_W:0] AGE_ONE = (TIMEOUT_W + 1)'(1);

  logic [DEPTH-1:0]     ent_vld, ent_hit, ent_exp;
  logic [7:0]           ent_chip [DEPTH];
  logic [7:0]           ent_addr [DEPTH];
  logic [TIMEOUT_W-1:0] ent_age  [DEPTH];

  logic [DEPTH-1:0] free_req, cand_req, exp_req, age_due;
  logic [IW-1:0]    alloc_idx, match_idx, exp_idx;
  logic             alloc_found, match_found, exp_found;

  packet_declare_t rx_decl;
  logic [7:0]      rx_chip, rx_addr, rx_dat;
  logic            rx_cfg_rd, do_alloc, do_match, do_unexp, timeout_fire, match_bcast;
  logic            unused_rx;

  assign rx_decl   = packet_declare_t'(rx_data[DECL_LSB +: DECL_W]);
  assign rx_chip   = rx_data[CHIP_LSB +: CHIP_W];
  assign rx_addr   = rx_data[ADDR_LSB +: ADDR_W];
  assign rx_dat    = rx_data[DATA_LSB +: DATA_W];
  assign unused_rx = ^rx_data[WIDTH-2:DATA_LSB+DATA_W];
  assign rx_cfg_rd = rx_valid & ~rx_parity_error & (rx_decl == CFG_READ);

  always_comb begin
    free_req = '0;
    cand_req = '0;
    exp_req  = '0;
    age_due  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_req[i] = ~ent_vld[i];
      cand_req[i] = ent_vld[i] & ~ent_exp[i] & (ent_addr[i] == rx_addr) &
                    ((ent_chip[i] == rx_chip) | (ent_chip[i] == GLOBAL_ID));
      exp_req[i]  = ent_vld[i] & ent_exp[i];
      age_due[i]  = ({1'b0, ent_age[i]} + AGE_ONE) >= {1'b0, timeout_cycles};
    end
  end

  mcp_prio_enc #(.N(DEPTH), .IW(IW)) u_alloc_enc (.req(free_req), .idx(alloc_idx), .found(alloc_found));
  mcp_prio_enc #(.N(DEPTH), .IW(IW)) u_match_enc (.req(cand_req), .idx(match_idx), .found(match_found));
  mcp_prio_enc #(.N(DEPTH), .IW(IW)) u_exp_enc   (.req(exp_req),  .idx(exp_idx),   .found(exp_found));

  assign req_ready    = alloc_found;
  assign do_alloc     = req_valid & alloc_found;
  assign do_match     = rx_cfg_rd & match_found;
  assign do_unexp     = rx_cfg_rd & ~match_found;
  assign match_bcast  = ent_chip[match_idx] == GLOBAL_ID;
  assign timeout_fire = exp_found & ~ent_hit[exp_idx];

  // Later assignments win: a same-cycle match retires before aging can expire it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_vld <= '0;
      ent_hit <= '0;
      ent_exp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_chip[i] <= '0;
        ent_addr[i] <= '0;
        ent_age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && !ent_exp[i] && (timeout_cycles != '0)) begin
          ent_age[i] <= ent_age[i] + TIMEOUT_W'(1);
          if (age_due[i]) ent_exp[i] <= 1'b1;
        end
        if (do_match && (match_idx == IW'(i))) begin
          if (match_bcast) ent_hit[i] <= 1'b1;
          else             ent_vld[i] <= 1'b0;
        end
        if (exp_found && (exp_idx == IW'(i))) ent_vld[i] <= 1'b0;
        if (do_alloc && (alloc_idx == IW'(i))) begin
          ent_vld[i]  <= 1'b1;
          ent_chip[i] <= req_chip_id;
          ent_addr[i] <= req_addr;
          ent_age[i]  <= '0;
          ent_hit[i]  <= 1'b0;
          ent_exp[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_valid      <= 1'b0;
      match_chip_id    <= '0;
      match_addr       <= '0;
      match_data       <= '0;
      timeout_valid    <= 1'b0;
      timeout_chip_id  <= '0;
      timeout_addr     <= '0;
      unexpected_valid <= 1'b0;
    end else begin
      match_valid      <= do_match;
      timeout_valid    <= timeout_fire;
      unexpected_valid <= do_unexp;
      if (do_match) begin
        match_chip_id <= rx_chip;
        match_addr    <= rx_addr;
        match_data    <= rx_dat;
      end
      if (timeout_fire) begin
        timeout_chip_id <= ent_chip[exp_idx];
        timeout_addr    <= ent_addr[exp_idx];
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < DEPTH; i++) outstanding = outstanding + CW'(ent_vld[i]);
  end

`ifdef MCP_SB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_match      <= '0;
      stat_timeout    <= '0;
      stat_unexpected <= '0;
      stat_parity     <= '0;
    end else begin
      if (do_match)                     stat_match      <= sat_inc(stat_match);
      if (timeout_fire)                 stat_timeout    <= sat_inc(stat_timeout);
      if (do_unexp)                     stat_unexpected <= sat_inc(stat_unexpected);
      if (rx_valid && rx_parity_error)  stat_parity     <= sat_inc(stat_parity);
    end
  end
`else
  assign stat_match      = '0;
  assign stat_timeout    = '0;
  assign stat_unexpected = '0;
  assign stat_parity     = '0;
`endif

endmodule

// File: tb/tb_mcp_cfg_read_scoreboard.sv
// Bench for mcp_cfg_read_scoreboard: directed scenarios plus random traffic against a table model.
module tb_mcp_cfg_read_scoreboard;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [7:0]  req_chip_id, req_addr;
  logic        rx_valid, rx_parity_error;
  logic [62:0] rx_data;
  logic [15:0] timeout_cycles;
  logic        match_valid, timeout_valid, unexpected_valid;
  logic [7:0]  match_chip_id, match_addr, match_data, timeout_chip_id, timeout_addr;
  logic [3:0]  outstanding;
  logic [15:0] stat_match, stat_timeout, stat_unexpected, stat_parity;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mcp_cfg_read_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_chip_id(req_chip_id), .req_addr(req_addr),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_parity_error(rx_parity_error),
    .timeout_cycles(timeout_cycles),
    .match_valid(match_valid), .match_chip_id(match_chip_id), .match_addr(match_addr),
    .match_data(match_data), .timeout_valid(timeout_valid), .timeout_chip_id(timeout_chip_id),
    .timeout_addr(timeout_addr), .unexpected_valid(unexpected_valid), .outstanding(outstanding),
    .stat_match(stat_match), .stat_timeout(stat_timeout), .stat_unexpected(stat_unexpected),
    .stat_parity(stat_parity)
  );

  // Reference model: table of requests, each slot aging from acceptance.
  logic       m_vld [DEPTH];
  logic       m_exp [DEPTH];
  logic       m_hit [DEPTH];
  logic [7:0] m_chip[DEPTH];
  logic [7:0] m_addr[DEPTH];
  int         m_age [DEPTH];
  logic       m_mv, m_tv, m_uv;
  logic [7:0] m_mchip, m_maddr, m_mdata, m_tchip, m_taddr;
  int         m_smatch, m_stimeout, m_sunexp, m_sparity;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_vld[i]) n++;
    return n;
  endfunction

  function automatic logic m_free();
    return m_count() < DEPTH;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 0; m_exp[i] = 0; m_hit[i] = 0; m_chip[i] = 0; m_addr[i] = 0; m_age[i] = 0;
    end
    m_mv = 0; m_tv = 0; m_uv = 0;
    m_smatch = 0; m_stimeout = 0; m_sunexp = 0; m_sparity = 0;
  endtask

  function automatic logic [62:0] pkt(input logic [1:0] decl, input logic [7:0] chip,
                                      input logic [7:0] addr, input logic [7:0] data);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    r[1:0] = decl; r[9:2] = chip; r[17:10] = addr; r[25:18] = data;
    return r[62:0];
  endfunction

  task automatic send_req(input logic [7:0] chip, input logic [7:0] addr);
    req_valid = 1'b1; req_chip_id = chip; req_addr = addr;
  endtask

  task automatic send_rx(input logic [1:0] decl, input logic [7:0] chip, input logic [7:0] addr,
                         input logic [7:0] data, input logic par);
    rx_valid = 1'b1; rx_data = pkt(decl, chip, addr, data); rx_parity_error = par;
  endtask

  // Advance one clock: update the model from the inputs presented this cycle, then clear strobes.
  task automatic tick();
    int cand = -1;
    int rep  = -1;
    int fr   = -1;
    logic good;
    logic [7:0] rc, ra, rd;
    rc = rx_data[9:2]; ra = rx_data[17:10]; rd = rx_data[25:18];
    good = rx_valid && !rx_parity_error && (rx_data[1:0] == 2'd3);
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_vld[i] && fr < 0) fr = i;
      if (m_vld[i] && m_exp[i] && rep < 0) rep = i;
      if (good && cand < 0 && m_vld[i] && !m_exp[i] && m_addr[i] == ra &&
          (m_chip[i] == rc || m_chip[i] == 8'd255)) cand = i;
    end
    m_mv = 0; m_tv = 0; m_uv = 0;
    if (rx_valid && rx_parity_error) m_sparity++;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_vld[i] && !m_exp[i] && timeout_cycles != 0) begin
        m_age[i]++;
        if (m_age[i] == int'(timeout_cycles)) m_exp[i] = 1;
      end
    end
    if (good) begin
      if (cand >= 0) begin
        m_mv = 1; m_mchip = rc; m_maddr = ra; m_mdata = rd; m_smatch++;
        if (m_chip[cand] == 8'd255) m_hit[cand] = 1;
        else m_vld[cand] = 0;
      end else begin
        m_uv = 1; m_sunexp++;
      end
    end
    if (rep >= 0) begin
      if (!m_hit[rep]) begin
        m_tv = 1; m_tchip = m_chip[rep]; m_taddr = m_addr[rep]; m_stimeout++;
      end
      m_vld[rep] = 0;
    end
    if (req_valid && fr >= 0) begin
      m_vld[fr] = 1; m_exp[fr] = 0; m_hit[fr] = 0; m_age[fr] = 0;
      m_chip[fr] = req_chip_id; m_addr[fr] = req_addr;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; rx_valid = 1'b0; rx_parity_error = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 0; req_chip_id = 0; req_addr = 0;
    rx_valid = 0; rx_data = '0; rx_parity_error = 0; timeout_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({match_valid, timeout_valid, unexpected_valid, outstanding, req_ready} !== {3'b000, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_ctrl got m%0b t%0b u%0b o%0d r%0b want 0 0 0 0 1",
               match_valid, timeout_valid, unexpected_valid, outstanding, req_ready);
    end
    vectors++;
    if ({match_chip_id, match_addr, match_data, timeout_chip_id, timeout_addr,
         stat_match, stat_timeout, stat_unexpected, stat_parity} !== '0) begin
      miscompares++;
      $display("FAIL reset_fields got %h %h %h %h %h %h %h %h %h want all zero", match_chip_id,
               match_addr, match_data, timeout_chip_id, timeout_addr, stat_match, stat_timeout,
               stat_unexpected, stat_parity);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic_match();
    send_req(8'd3, 8'h10); tick();
    vectors++;
    if (outstanding !== 4'd1) begin
      miscompares++; $display("FAIL basic_outstanding1 got %0d want 1", outstanding);
    end
    send_rx(2'd3, 8'd3, 8'h10, 8'hA5, 1'b0); tick();
    vectors++;
    if ({match_valid, match_chip_id, match_addr, match_data, outstanding} !== {1'b1, 8'd3, 8'h10, 8'hA5, 4'd0}) begin
      miscompares++;
      $display("FAIL basic_match got v%0b %h/%h/%h o%0d want 1 03/10/a5 o0",
               match_valid, match_chip_id, match_addr, match_data, outstanding);
    end
    tick();
    vectors++;
    if ({match_valid, match_data} !== {1'b0, 8'hA5}) begin
      miscompares++; $display("FAIL basic_pulse_hold got v%0b d%h want 0 a5", match_valid, match_data);
    end
    send_req(8'd7, 8'h20); send_rx(2'd3, 8'd7, 8'h20, 8'h5A, 1'b0); tick();
    vectors++;
    if ({match_valid, unexpected_valid, outstanding} !== {1'b0, 1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL same_cycle_resp got m%0b u%0b o%0d want 0 1 1", match_valid, unexpected_valid, outstanding);
    end
    send_rx(2'd3, 8'd7, 8'h20, 8'h5A, 1'b0); tick();
    vectors++;
    if ({match_valid, match_chip_id, match_data} !== {1'b1, 8'd7, 8'h5A}) begin
      miscompares++;
      $display("FAIL later_match got v%0b c%h d%h want 1 07 5a", match_valid, match_chip_id, match_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      send_req(8'(10 + i), 8'(i)); tick();
    end
    vectors++;
    if ({req_ready, outstanding} !== {1'b0, 4'd8}) begin
      miscompares++; $display("FAIL fill_full got r%0b o%0d want 0 8", req_ready, outstanding);
    end
    send_req(8'd99, 8'd99); tick();
    vectors++;
    if (outstanding !== 4'd8) begin
      miscompares++; $display("FAIL fill_ninth_ignored got o%0d want 8", outstanding);
    end
    send_rx(2'd3, 8'd12, 8'd2, 8'h11, 1'b0); send_req(8'd98, 8'd98); tick();
    vectors++;
    if ({match_valid, match_chip_id, outstanding, req_ready} !== {1'b1, 8'd12, 4'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL fill_retire got v%0b c%0d o%0d r%0b want 1 12 7 1",
               match_valid, match_chip_id, outstanding, req_ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 2) continue;
      send_rx(2'd3, 8'(10 + i), 8'(i), 8'(i), 1'b0); tick();
      vectors++;
      if ({match_valid, match_chip_id} !== {1'b1, 8'(10 + i)}) begin
        miscompares++;
        $display("FAIL fill_drain%0d got v%0b c%0d want 1 %0d", i, match_valid, match_chip_id, 10 + i);
      end
    end
    vectors++;
    if (outstanding !== 4'd0) begin
      miscompares++; $display("FAIL fill_empty got o%0d want 0", outstanding);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int at = -1;
    timeout_cycles = 16'd20;
    send_req(8'd5, 8'h30); tick();
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (timeout_valid) begin
        n++;
        if (at < 0) at = c;
      end
    end
    vectors++;
    if (n != 1 || at != 21 || {timeout_chip_id, timeout_addr, outstanding} !== {8'd5, 8'h30, 4'd0}) begin
      miscompares++;
      $display("FAIL timeout_once got n%0d at%0d %h/%h o%0d want 1 21 05/30 0",
               n, at, timeout_chip_id, timeout_addr, outstanding);
    end
    timeout_cycles = 16'd0;
    n = 0;
    send_req(8'd6, 8'h31); tick();
    for (int c = 0; c < 60; c++) begin
      tick();
      if (timeout_valid) n++;
    end
    vectors++;
    if (n != 0 || outstanding !== 4'd1) begin
      miscompares++; $display("FAIL timeout_disabled got n%0d o%0d want 0 1", n, outstanding);
    end
    send_rx(2'd3, 8'd6, 8'h31, 8'h00, 1'b0); tick();
  endtask

  task automatic test_broadcast();
    int n = 0;
    timeout_cycles = 16'd20;
    send_req(8'd255, 8'h05); tick();
    send_rx(2'd3, 8'd1, 8'h05, 8'h11, 1'b0); tick();
    vectors++;
    if ({match_valid, match_chip_id, match_addr, match_data} !== {1'b1, 8'd1, 8'h05, 8'h11}) begin
      miscompares++;
      $display("FAIL bcast_first got v%0b %h/%h/%h want 1 01/05/11", match_valid, match_chip_id, match_addr, match_data);
    end
    send_rx(2'd3, 8'd2, 8'h05, 8'h22, 1'b0); tick();
    vectors++;
    if ({match_valid, match_chip_id, match_data, outstanding} !== {1'b1, 8'd2, 8'h22, 4'd1}) begin
      miscompares++;
      $display("FAIL bcast_second got v%0b c%h d%h o%0d want 1 02 22 1",
               match_valid, match_chip_id, match_data, outstanding);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      if (timeout_valid) n++;
    end
    vectors++;
    if (n != 0 || outstanding !== 4'd0) begin
      miscompares++; $display("FAIL bcast_silent_retire got n%0d o%0d want 0 0", n, outstanding);
    end
  endtask

  task automatic test_parity_unexpected();
    logic [15:0] want_par;
`ifdef MCP_SB_STATS_EN
    want_par = 16'd1;
`else
    want_par = 16'd0;
`endif
    timeout_cycles = 16'd0;
    send_req(8'd4, 8'h40); tick();
    send_rx(2'd3, 8'd4, 8'h40, 8'h33, 1'b1); tick();
    vectors++;
    if ({match_valid, unexpected_valid, stat_parity} !== {2'b00, want_par}) begin
      miscompares++;
      $display("FAIL parity_drop got m%0b u%0b p%0d want 0 0 %0d", match_valid, unexpected_valid, stat_parity, want_par);
    end
    send_rx(2'd2, 8'd4, 8'h40, 8'h33, 1'b0); tick();
    vectors++;
    if ({match_valid, unexpected_valid, outstanding} !== {2'b00, 4'd1}) begin
      miscompares++;
      $display("FAIL declare2_ignored got m%0b u%0b o%0d want 0 0 1", match_valid, unexpected_valid, outstanding);
    end
    send_rx(2'd3, 8'd4, 8'h77, 8'h33, 1'b0); tick();
    vectors++;
    if ({match_valid, unexpected_valid} !== 2'b01) begin
      miscompares++; $display("FAIL unexpected_addr got m%0b u%0b want 0 1", match_valid, unexpected_valid);
    end
    send_rx(2'd3, 8'd4, 8'h40, 8'h44, 1'b0); tick();
    vectors++;
    if ({match_valid, match_data, outstanding} !== {1'b1, 8'h44, 4'd0}) begin
      miscompares++;
      $display("FAIL parity_cleanup got v%0b d%h o%0d want 1 44 0", match_valid, match_data, outstanding);
    end
  endtask

  task automatic test_multi_expiry();
    int at[$];
    logic [7:0] ch[$];
    timeout_cycles = 16'd0;
    for (int i = 0; i < 3; i++) begin
      send_req(8'(21 + i), 8'(1 + i)); tick();
    end
    timeout_cycles = 16'd5;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (timeout_valid) begin
        at.push_back(c); ch.push_back(timeout_chip_id);
      end
    end
    vectors++;
    if (at.size() != 3) begin
      miscompares++; $display("FAIL multi_exp_count got %0d want 3", at.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (at[k] != 6 + k || ch[k] !== 8'(21 + k)) begin
          miscompares++;
          $display("FAIL multi_exp%0d got cyc%0d c%0d want cyc%0d c%0d", k, at[k], ch[k], 6 + k, 21 + k);
        end
      end
    end
    timeout_cycles = 16'd0;
  endtask

  task automatic test_reset_mid();
    send_req(8'd30, 8'd1); tick();
    send_rx(2'd3, 8'd30, 8'd1, 8'h99, 1'b0); send_req(8'd31, 8'd2); tick();
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({match_valid, match_chip_id, match_data, outstanding, req_ready} !== {1'b0, 8'd0, 8'd0, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_mid got v%0b c%h d%h o%0d r%0b want 0 00 00 0 1",
               match_valid, match_chip_id, match_data, outstanding, req_ready);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    tick();
    vectors++;
    if ({match_valid, timeout_valid, unexpected_valid, outstanding} !== 7'd0) begin
      miscompares++; $display("FAIL reset_mid_after got %b want 0", {match_valid, timeout_valid, unexpected_valid, outstanding});
    end
  endtask

  task automatic test_random();
    logic [7:0] chips [4] = '{8'd1, 8'd2, 8'd3, 8'd255};
    logic [1:0] decl;
    int cycles = 700;
    timeout_cycles = 16'($urandom_range(8, 40));
    for (int c = 0; c < cycles + 60; c++) begin
      if (c < cycles) begin
        if ($urandom_range(0, 2) == 0) send_req(chips[$urandom_range(0, 3)], 8'($urandom_range(0, 3)));
        if ($urandom_range(0, 1) == 0) begin
          decl = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
          send_rx(decl, 8'($urandom_range(1, 4)), 8'($urandom_range(0, 4)), 8'($urandom),
                  $urandom_range(0, 9) == 0);
        end
      end
      vectors++;
      if (req_ready !== m_free()) begin
        miscompares++; $display("FAIL rand_ready c%0d got %0b want %0b", c, req_ready, m_free());
      end
      tick();
      vectors++;
      if ({match_valid, timeout_valid, unexpected_valid, outstanding} !== {m_mv, m_tv, m_uv, 4'(m_count())}) begin
        miscompares++;
        $display("FAIL rand_ctrl c%0d got m%0b t%0b u%0b o%0d want %0b %0b %0b %0d", c, match_valid,
                 timeout_valid, unexpected_valid, outstanding, m_mv, m_tv, m_uv, m_count());
      end
      if (m_mv) begin
        vectors++;
        if ({match_chip_id, match_addr, match_data} !== {m_mchip, m_maddr, m_mdata}) begin
          miscompares++;
          $display("FAIL rand_match c%0d got %h/%h/%h want %h/%h/%h", c, match_chip_id, match_addr,
                   match_data, m_mchip, m_maddr, m_mdata);
        end
      end
      if (m_tv) begin
        vectors++;
        if ({timeout_chip_id, timeout_addr} !== {m_tchip, m_taddr}) begin
          miscompares++;
          $display("FAIL rand_timeout c%0d got %h/%h want %h/%h", c, timeout_chip_id, timeout_addr, m_tchip, m_taddr);
        end
      end
    end
    vectors++;
`ifdef MCP_SB_STATS_EN
    if ({stat_match, stat_timeout, stat_unexpected, stat_parity} !==
        {16'(m_smatch), 16'(m_stimeout), 16'(m_sunexp), 16'(m_sparity)}) begin
`else
    if ({stat_match, stat_timeout, stat_unexpected, stat_parity} !== 64'd0) begin
`endif
      miscompares++;
      $display("FAIL rand_stats got %0d %0d %0d %0d model %0d %0d %0d %0d", stat_match, stat_timeout,
               stat_unexpected, stat_parity, m_smatch, m_stimeout, m_sunexp, m_sparity);
    end
  endtask

  initial begin
    test_reset();
    test_basic_match();
    test_fill();
    test_timeout();
    test_broadcast();
    test_parity_unexpected();
    test_multi_expiry();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcp_cfg_read_scoreboard.md
# mcp_cfg_read_scoreboard

Synthesizable, bounded successor to the master-side packet scoreboard. It sits between the FPGA TX path, which issues configuration-read requests to LArPix, and the FPGA UART RX path, which delivers received packets. It tracks up to DEPTH outstanding reads and matches configuration-read responses by chip ID and register address. It reports matches, timeouts and unsolicited responses, and handles global-broadcast reads answered by several chips.

## Interface
Parameters:
- WIDTH, 64: UART frame width; received packet is WIDTH-1 bits.
- DEPTH, 8: outstanding-request table entries, ≥2.
- TIMEOUT_W, 16: width of age counters and timeout setting.
- GLOBAL_ID, 255: broadcast chip ID.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  config read issued this cycle.
- req_ready  out  1  table has a free entry.
- req_chip_id  in  8  target chip.
- req_addr  in  8  register address.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- rx_data  in  WIDTH-1  received packet.
- rx_parity_error  in  1  qualifies rx_data.
- timeout_cycles  in  TIMEOUT_W  cycles before an entry expires; 0 = never.
- match_valid  out  1  one-cycle pulse.
- match_chip_id, match_addr, match_data  out  8 each  matched response fields.
- timeout_valid  out  1  one-cycle pulse.
- timeout_chip_id, timeout_addr  out  8 each  expired request.
- unexpected_valid  out  1  config-read response with no matching entry.
- outstanding  out  $clog2(DEPTH+1)  valid entry count.
- stat_match, stat_timeout, stat_unexpected, stat_parity  out  16 each  saturating counters.

## Operation
- Entry fields: valid, chip_id, addr, age[TIMEOUT_W], hit (broadcast only), expired.
- Allocation: when req_valid & req_ready, write to the lowest-index free entry. age=0, hit=0. req_valid while full is ignored.
- Packet decode: declare=rx_data[1:0], chip=[9:2], addr=[17:10], data=[25:18].
- Packets with parity error are dropped; increment stat_parity. Declare 0/1/2 are ignored.
- Declare 3, good parity, matching procedure:
  - Candidate entries: valid, not expired, addr equal, and chip_id equal or chip_id==GLOBAL_ID.
  - Select the lowest index among candidates.
  - Unicast entry: retire it and pulse match.
  - Broadcast entry: set hit, pulse match with the responder's chip ID, keep the entry.
  - No candidate: pulse unexpected_valid.
- Aging: each valid entry increments age per cycle while timeout_cycles≠0. At age==timeout_cycles it becomes expired and age holds.
- Expiry reporting: one expired entry per cycle, lowest index first.
  - Unicast entry, or broadcast entry with hit=0: pulse timeout_valid and retire.
  - Broadcast entry with hit=1: retire silently.
- outstanding counts valid entries, including expired entries not yet reported.

## Timing
- Reset: all entries invalid. All pulses, output fields, counters and outstanding are 0. req_ready=1.
- match, unexpected and timeout outputs are registered: they assert the cycle after the causing rx_valid or expiry, and fields hold until the next pulse.
- A request accepted in cycle N becomes matchable from cycle N+1; a same-cycle response cannot match it.
- Free-slot view uses pre-retirement state: a slot retired in cycle N is allocatable from N+1. req_ready is combinational from registered state.
- Match and expiry on the same entry in the same cycle: the match wins and no timeout is reported.
- match and timeout may pulse in the same cycle (different entries).
- Reset mid-operation clears the table immediately; no pending pulses survive.
- Counters saturate at 0xFFFF.

## Configuration
- MCP_SB_STATS_EN defined: the four stat counters are implemented.
- Undefined: the stat_* ports are tied to 0 and no counter flops exist. Matching, timeout and outputs are otherwise identical.

## Structure
- Shared package mcp_pkg holds:
  - packet_declare_t enum: DATA=0, TEST=1, CFG_WRITE=2, CFG_READ=3.
  - Field offset/width localparams.
  - GLOBAL_ID default.
- Sub-module mcp_prio_enc: parametrised lowest-set-bit encoder with found flag. Three instances: allocation, match selection, expiry reporting.

## Test plan
- Reset, then request (chip 3, addr 0x10); response declare=3, chip 3, addr 0x10, data 0xA5 → match_valid one cycle later with 3/0x10/0xA5, outstanding 1→0.
- Fill 8 requests → req_ready=0. A 9th is ignored. One match → req_ready=1 the next cycle.
- timeout_cycles=20, request with no response → timeout_valid exactly once, about 21 cycles after the request, then outstanding=0. timeout_cycles=0 → never expires.
- Broadcast read addr 0x05; responses from chips 1 and 2 → two match pulses with chip IDs 1 and 2, silent retire at expiry, no timeout_valid.
- Response with parity error → no match; stat_parity=1 (MCP_SB_STATS_EN). Response for an unknown addr → unexpected_valid.
- Three entries expiring in the same cycle → timeout_valid on three consecutive cycles in index order.
